ahb_sram_ctrl: RTL and testbench

AHB_SRAM_CTRL -- requirements
Module: ahb_sram_ctrl

---
 rtl/ahb_sram_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_ahb_sram_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite slave bridging to a single-port synchronous SRAM (byte/half/word, ERROR on bad accesses).
// Latency: write completes WAIT_STATES cycles after address phase, read 1+WAIT_STATES; ERROR is 2 cycles.
// Backpressure: hreadyout low stalls the master; address-phase inputs are ignored while it is low.
//
// Ports:
//   hclk, hresetn                      clock, async active-low reset
//   hsel/haddr/htrans/hwrite/hsize/    AHB-Lite request side (hready is the bus-wide ready)
//   hready/hwdata
//   hrdata/hreadyout/hresp             AHB-Lite response side
//   sram_cs/sram_we/sram_be/sram_addr/ synchronous SRAM; read data valid the cycle after the strobe
//   sram_wdata/sram_rdata
module ahb_sram_ctrl #(
   parameter int WAIT_STATES = 0,      // 0..3 extra data-phase cycles
   parameter int MEM_BYTES   = 65536   // bytes of SRAM behind the slave
) (
   input  logic        hclk,
   input  logic        hresetn,
   input  logic        hsel,
   input  logic [15:0] haddr,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic        hready,
   input  logic [31:0] hwdata,
   output logic [31:0] hrdata,
   output logic        hreadyout,
   output logic        hresp,
   output logic        sram_cs,
   output logic        sram_we,
   output logic [3:0]  sram_be,
   output logic [13:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WRITE = 3'd1,
      S_READ  = 3'd2,
      S_ERR1  = 3'd3,
      S_ERR2  = 3'd4
   } state_t;

   localparam logic [2:0]  WR_LAST = 3'(WAIT_STATES);
   localparam logic [2:0]  RD_LAST = 3'(WAIT_STATES + 1);
   localparam logic [16:0] MEM_LIM = 17'(MEM_BYTES);

   state_t      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [15:0] addr_q, addr_d;
   logic [2:0]  size_q, size_d;

   logic        wr_last, rd_last, can_accept, accept;
   logic        misalign, out_of_range, req_err;
   logic [3:0]  be_calc;

   // htrans[0] only distinguishes SEQ/NONSEQ and IDLE/BUSY; neither changes behaviour here.
   logic        unused_htrans0;
   assign unused_htrans0 = htrans[0];

   // Final data-phase cycle of a transfer: the only write cycle that strobes, and the read
   // cycle where the SRAM data (fetched by the first-cycle strobe) is returned.
   assign wr_last = (state_q == S_WRITE) && (cnt_q == WR_LAST);
   assign rd_last = (state_q == S_READ)  && (cnt_q == RD_LAST);

   // A new address phase can only be taken in a cycle where this slave drives hreadyout=1.
   assign can_accept = (state_q == S_IDLE) || (state_q == S_ERR2) || wr_last || rd_last;
   assign accept     = can_accept && hsel && hready && htrans[1];

   assign misalign     = ((hsize == 3'd1) && haddr[0]) ||
                         ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
   assign out_of_range = ({1'b0, haddr} >= MEM_LIM);
   assign req_err      = (hsize > 3'd2) || misalign || out_of_range;

   // State register
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
         addr_q  <= 16'd0;
         size_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      size_d  = size_q;
      case (state_q)
         S_IDLE, S_ERR2: begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
         end
         S_ERR1: begin
            state_d = S_ERR2;
            cnt_d   = 3'd0;
         end
         S_WRITE: begin
            if (wr_last) begin
               state_d = S_IDLE;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_READ: begin
            if (rd_last) begin
               state_d = S_IDLE;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
         end
      endcase
      // Accepting overrides the default return to IDLE: back-to-back pipelining.
      if (accept) begin
         if (req_err) begin
            state_d = S_ERR1;
         end else if (hwrite) begin
            state_d = S_WRITE;
         end else begin
            state_d = S_READ;
         end
         cnt_d  = 3'd0;
         addr_d = haddr;
         size_d = hsize;
      end
   end

   // Byte lanes from the registered size/offset
   always_comb begin
      be_calc = 4'b0000;
      case (size_q)
         3'd0:    be_calc = 4'b0001 << addr_q[1:0];
         3'd1:    be_calc = addr_q[1] ? 4'b1100 : 4'b0011;
         default: be_calc = 4'b1111;
      endcase
   end

   assign sram_addr = addr_q[15:2];

   // Output logic
   always_comb begin
      hreadyout  = 1'b1;
      hresp      = 1'b0;
      hrdata     = 32'd0;
      sram_cs    = 1'b0;
      sram_we    = 1'b0;
      sram_be    = 4'b0000;
      sram_wdata = 32'd0;
      case (state_q)
         S_WRITE: begin
            hreadyout = wr_last;
            if (wr_last) begin
               sram_cs    = 1'b1;
               sram_we    = 1'b1;
               sram_be    = be_calc;
               sram_wdata = hwdata;
            end
         end
         S_READ: begin
            hreadyout = rd_last;
            if (cnt_q == 3'd0) begin
               sram_cs = 1'b1;
               sram_be = be_calc;
            end
            if (rd_last) begin
               hrdata = sram_rdata;
            end
         end
         S_ERR1: begin
            hreadyout = 1'b0;
            hresp     = 1'b1;
         end
         S_ERR2: begin
            hresp = 1'b1;
         end
         default: begin
            hreadyout = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Bench for ahb_sram_ctrl: two instances (WAIT_STATES=0 / 64 KiB and WAIT_STATES=2 / 32 KiB)
// share one AHB master; dut_sel routes hsel and picks which responses are observed.
// Each instance has its own behavioural SRAM; a byte-array model predicts every read.
module tb_ahb_sram_ctrl;

   bit hclk = 1'b0;
   always #5 hclk = ~hclk;

   logic        hresetn;
   logic        hsel;
   logic [15:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [31:0] hwdata;
   bit          dut_sel;

   logic [31:0] rdata0, rdata1, wdata0, wdata1;
   logic        rdy0, rdy1, resp0, resp1, cs0, cs1, we0, we1;
   logic [3:0]  be0, be1;
   logic [13:0] addr0, addr1;
   bit   [31:0] srd0, srd1;

   logic [31:0] m_rdata, m_wdata;
   logic        m_rdy, m_resp, m_cs, m_we;
   logic [3:0]  m_be;
   logic [13:0] m_addr;
   logic        hsel0, hsel1, hready;

   assign hsel0   = hsel && !dut_sel;
   assign hsel1   = hsel && dut_sel;
   assign m_rdy   = dut_sel ? rdy1   : rdy0;
   assign m_resp  = dut_sel ? resp1  : resp0;
   assign m_rdata = dut_sel ? rdata1 : rdata0;
   assign m_cs    = dut_sel ? cs1    : cs0;
   assign m_we    = dut_sel ? we1    : we0;
   assign m_be    = dut_sel ? be1    : be0;
   assign m_addr  = dut_sel ? addr1  : addr0;
   assign m_wdata = dut_sel ? wdata1 : wdata0;
   assign hready  = m_rdy;

   ahb_sram_ctrl #(.WAIT_STATES(0), .MEM_BYTES(65536)) u_dut0 (
      .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hready(hready), .hwdata(hwdata),
      .hrdata(rdata0), .hreadyout(rdy0), .hresp(resp0),
      .sram_cs(cs0), .sram_we(we0), .sram_be(be0), .sram_addr(addr0),
      .sram_wdata(wdata0), .sram_rdata(srd0));

   ahb_sram_ctrl #(.WAIT_STATES(2), .MEM_BYTES(32768)) u_dut1 (
      .hclk(hclk), .hresetn(hresetn), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
      .hwrite(hwrite), .hsize(hsize), .hready(hready), .hwdata(hwdata),
      .hrdata(rdata1), .hreadyout(rdy1), .hresp(resp1),
      .sram_cs(cs1), .sram_we(we1), .sram_be(be1), .sram_addr(addr1),
      .sram_wdata(wdata1), .sram_rdata(srd1));

   // Behavioural synchronous SRAMs with byte enables
   bit   [31:0] sram0 [0:16383];
   bit   [31:0] sram1 [0:16383];
   logic [31:0] t0, t1;

   always @(posedge hclk) begin
      if (cs0) begin
         if (we0) begin
            t0 = sram0[addr0];
            for (int i = 0; i < 4; i++) if (be0[i]) t0[8*i +: 8] = wdata0[8*i +: 8];
            sram0[addr0] <= t0;
         end else begin
            srd0 <= sram0[addr0];
         end
      end
      if (cs1) begin
         if (we1) begin
            t1 = sram1[addr1];
            for (int i = 0; i < 4; i++) if (be1[i]) t1[8*i +: 8] = wdata1[8*i +: 8];
            sram1[addr1] <= t1;
         end else begin
            srd1 <= sram1[addr1];
         end
      end
   end

   // Reference model: plain byte-addressed memory per instance
   bit [7:0] refm [0:1][0:65535];

   function automatic int ws_of(int d);
      return (d != 0) ? 2 : 0;
   endfunction

   function automatic bit ref_err(int d, logic [2:0] sz, logic [15:0] a);
      int lim = (d != 0) ? 32768 : 65536;
      if (sz > 3'd2) return 1'b1;
      if (int'(a) % (1 << sz) != 0) return 1'b1;
      return int'(a) >= lim;
   endfunction

   function automatic logic [3:0] ref_be(logic [2:0] sz, logic [15:0] a);
      logic [3:0] m = 4'b0000;
      for (int i = 0; i < (1 << sz); i++) m[(int'(a) + i) % 4] = 1'b1;
      return m;
   endfunction

   function automatic void ref_write(int d, logic [2:0] sz, logic [15:0] a, logic [31:0] wd);
      for (int i = 0; i < (1 << sz); i++) begin
         int ad = int'(a) + i;
         refm[d][ad] = wd[8*(ad % 4) +: 8];
      end
   endfunction

   function automatic logic [31:0] ref_word(int d, logic [15:0] a);
      int w = int'(a) & 32'hFFFC;
      return {refm[d][w+3], refm[d][w+2], refm[d][w+1], refm[d][w]};
   endfunction

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   typedef struct {
      bit          done;
      logic        err;
      int          waits;
      int          strobes;
      int          resp_cyc;
      logic [3:0]  be;
      logic [13:0] sa;
      logic [31:0] rd;
      int          bad_we;
      int          bad_wd;
      int          rd_nz;
   } obs_t;

   // One single transfer, starting at posedge+1 with the slave ready. With noise set, address-phase
   // garbage is driven in every cycle the slave holds hreadyout low (it must be ignored).
   task automatic xfer(input bit wr, input logic [2:0] sz, input logic [15:0] a,
                       input logic [31:0] wd, input bit noise, output obs_t o);
      o.done = 0; o.err = 0; o.waits = 0; o.strobes = 0; o.resp_cyc = 0;
      o.be = 0; o.sa = 0; o.rd = 0; o.bad_we = 0; o.bad_wd = 0; o.rd_nz = 0;
      hsel = 1; htrans = 2'b10; haddr = a; hwrite = wr; hsize = sz; hwdata = $urandom;
      @(posedge hclk); #1;
      hwdata = wd;
      for (int k = 0; k < 12 && !o.done; k++) begin
         if (noise && !m_rdy) begin
            hsel = 1; htrans = 2'b10 | 2'($urandom_range(0, 1)); haddr = 16'($urandom);
            hwrite = 1'($urandom); hsize = 3'($urandom_range(0, 3));
         end else begin
            hsel = 0; htrans = 2'b00;
         end
         @(negedge hclk);
         if (m_resp) o.resp_cyc++;
         if (m_cs) begin
            o.strobes++; o.be = m_be; o.sa = m_addr;
            if (m_we !== wr) o.bad_we++;
            if (wr && m_wdata !== wd) o.bad_wd++;
         end
         if (m_rdy) begin
            o.done = 1; o.err = m_resp; o.rd = m_rdata;
         end else begin
            o.waits++;
            if (m_rdata !== 32'd0) o.rd_nz++;
         end
         @(posedge hclk); #1;
      end
      hsel = 0; htrans = 2'b00;
      chk("xfer_done", o.done, 1);
   endtask

   // Word write immediately followed by a word read of the same address (pipelined).
   task automatic b2b(input logic [15:0] a, input logic [31:0] wd, output bit [15:0] rdy_log,
                      output bit [15:0] cs_log, output bit [15:0] we_log,
                      output logic [31:0] rd, output int ncyc);
      int comps = 0;
      bit done  = 0;
      rdy_log = 0; cs_log = 0; we_log = 0; rd = 0; ncyc = 0;
      hsel = 1; htrans = 2'b10; haddr = a; hwrite = 1; hsize = 3'd2;
      @(posedge hclk); #1;
      hwdata = wd; hwrite = 0;
      for (int k = 0; k < 16 && !done; k++) begin
         @(negedge hclk);
         rdy_log[k] = m_rdy; cs_log[k] = m_cs; we_log[k] = m_we; ncyc = k + 1;
         if (m_rdy) comps++;
         if (comps == 2) begin rd = m_rdata; done = 1; end
         @(posedge hclk); #1;
         if (comps >= 1) begin hsel = 0; htrans = 2'b00; end
      end
      hsel = 0; htrans = 2'b00;
      chk("b2b_done", done, 1);
   endtask

   typedef struct {
      bit          wr;
      logic [2:0]  sz;
      logic [15:0] a;
      logic [31:0] wd;
      bit          e_err;
      int          e_waits;
      logic [3:0]  e_be;
      logic [13:0] e_sa;
      logic [31:0] e_rd;
   } vec_t;

   vec_t tbl [15];

   initial begin
      obs_t        o;
      bit   [15:0] rl, cl, wl;
      logic [31:0] rd;
      int          nc;
      bit          cs_seen;

      //          wr sz    addr      wdata         err waits be    sa        rdata
      tbl[0]  = '{1, 3'd2, 16'h0010, 32'hDEADBEEF, 0, 0, 4'hF, 14'h0004, 32'h00000000};
      tbl[1]  = '{0, 3'd2, 16'h0010, 32'h00000000, 0, 1, 4'hF, 14'h0004, 32'hDEADBEEF};
      tbl[2]  = '{1, 3'd0, 16'h0013, 32'hAA000000, 0, 0, 4'h8, 14'h0004, 32'h00000000};
      tbl[3]  = '{0, 3'd2, 16'h0010, 32'h00000000, 0, 1, 4'hF, 14'h0004, 32'hAAADBEEF};
      tbl[4]  = '{0, 3'd2, 16'h0002, 32'h00000000, 1, 1, 4'h0, 14'h0000, 32'h00000000};
      tbl[5]  = '{1, 3'd1, 16'h0012, 32'h12340000, 0, 0, 4'hC, 14'h0004, 32'h00000000};
      tbl[6]  = '{0, 3'd1, 16'h0012, 32'h00000000, 0, 1, 4'hC, 14'h0004, 32'h1234BEEF};
      tbl[7]  = '{1, 3'd1, 16'h0011, 32'h00005555, 1, 1, 4'h0, 14'h0000, 32'h00000000};
      tbl[8]  = '{0, 3'd3, 16'h0020, 32'h00000000, 1, 1, 4'h0, 14'h0000, 32'h00000000};
      tbl[9]  = '{1, 3'd0, 16'h0020, 32'h00000055, 0, 0, 4'h1, 14'h0008, 32'h00000000};
      tbl[10] = '{0, 3'd0, 16'h0021, 32'h00000000, 0, 1, 4'h2, 14'h0008, 32'h00000055};
      tbl[11] = '{1, 3'd1, 16'h0020, 32'h1111ABCD, 0, 0, 4'h3, 14'h0008, 32'h00000000};
      tbl[12] = '{0, 3'd2, 16'h0020, 32'h00000000, 0, 1, 4'hF, 14'h0008, 32'h0000ABCD};
      tbl[13] = '{0, 3'd2, 16'hFFFC, 32'h00000000, 0, 1, 4'hF, 14'h3FFF, 32'h00000000};
      tbl[14] = '{1, 3'd0, 16'h0016, 32'h00770000, 0, 0, 4'h4, 14'h0005, 32'h00000000};

      // Reset values
      hresetn = 0; hsel = 0; haddr = 0; htrans = 0; hwrite = 0; hsize = 0; hwdata = 0;
      dut_sel = 0;
      #12;
      chk("rst_hreadyout0", rdy0, 1);   chk("rst_hreadyout1", rdy1, 1);
      chk("rst_hresp", resp0, 0);       chk("rst_hrdata", rdata0, 0);
      chk("rst_cs", cs0, 0);            chk("rst_we", we0, 0);
      chk("rst_be", be0, 0);            chk("rst_addr", addr0, 0);
      @(negedge hclk); hresetn = 1;
      @(posedge hclk); #1;

      // Directed single transfers, WAIT_STATES=0
      foreach (tbl[i]) begin
         xfer(tbl[i].wr, tbl[i].sz, tbl[i].a, tbl[i].wd, 1'b0, o);
         chk($sformatf("tbl%0d_err", i), o.err, tbl[i].e_err);
         chk($sformatf("tbl%0d_waits", i), o.waits, tbl[i].e_waits);
         chk($sformatf("tbl%0d_strobes", i), o.strobes, tbl[i].e_err ? 0 : 1);
         chk($sformatf("tbl%0d_resp_cycles", i), o.resp_cyc, tbl[i].e_err ? 2 : 0);
         chk($sformatf("tbl%0d_hrdata", i), o.rd, tbl[i].e_rd);
         chk($sformatf("tbl%0d_hrdata_idle", i), o.rd_nz, 0);
         if (!tbl[i].e_err) begin
            chk($sformatf("tbl%0d_be", i), o.be, tbl[i].e_be);
            chk($sformatf("tbl%0d_sram_addr", i), o.sa, tbl[i].e_sa);
            chk($sformatf("tbl%0d_we", i), o.bad_we, 0);
            chk($sformatf("tbl%0d_wdata", i), o.bad_wd, 0);
            if (tbl[i].wr) ref_write(0, tbl[i].sz, tbl[i].a, tbl[i].wd);
         end
      end

      // Back-to-back write/read: WAIT_STATES=0 then WAIT_STATES=2
      dut_sel = 0;
      b2b(16'h0080, 32'h13572468, rl, cl, wl, rd, nc);
      ref_write(0, 3'd2, 16'h0080, 32'h13572468);
      chk("b2b0_cycles", nc, 3);       chk("b2b0_ready", rl, 16'h0005);
      chk("b2b0_cs", cl, 16'h0003);    chk("b2b0_we", wl, 16'h0001);
      chk("b2b0_rdata", rd, 32'h13572468);
      dut_sel = 1;
      b2b(16'h0040, 32'hCAFEF00D, rl, cl, wl, rd, nc);
      ref_write(1, 3'd2, 16'h0040, 32'hCAFEF00D);
      chk("b2b2_cycles", nc, 7);       chk("b2b2_ready", rl, 16'h0044);
      chk("b2b2_cs", cl, 16'h000C);    chk("b2b2_we", wl, 16'h0004);
      chk("b2b2_rdata", rd, 32'hCAFEF00D);

      // Address range boundary on the 32 KiB instance
      xfer(1'b0, 3'd2, 16'h8000, 32'h0, 1'b0, o);
      chk("oob_err", o.err, 1); chk("oob_strobes", o.strobes, 0); chk("oob_resp_cycles", o.resp_cyc, 2);
      xfer(1'b1, 3'd2, 16'h7FFC, 32'h0BADCAFE, 1'b0, o);
      ref_write(1, 3'd2, 16'h7FFC, 32'h0BADCAFE);
      chk("top_wr_err", o.err, 0); chk("top_wr_waits", o.waits, 2); chk("top_wr_addr", o.sa, 14'h1FFF);

      // Reset during the second wait cycle of a WAIT_STATES=2 read
      hsel = 1; htrans = 2'b10; haddr = 16'h0040; hwrite = 0; hsize = 3'd2;
      @(posedge hclk); #1;
      hsel = 0; htrans = 2'b00;
      @(negedge hclk);
      chk("arst_rd_strobe", m_cs, 1); chk("arst_rd_wait", m_rdy, 0);
      @(posedge hclk); #3;
      hresetn = 0;
      #1;
      chk("arst_hreadyout", m_rdy, 1); chk("arst_hresp", m_resp, 0);
      chk("arst_hrdata", m_rdata, 0);  chk("arst_cs", m_cs, 0);
      chk("arst_we", m_we, 0);         chk("arst_be", m_be, 0);
      chk("arst_addr", m_addr, 0);
      cs_seen = 0;
      repeat (3) begin @(negedge hclk); cs_seen |= m_cs; end
      chk("arst_no_strobe", cs_seen, 0);
      hresetn = 1;
      @(posedge hclk); #1;
      hsel = 1; htrans = 2'b00;
      @(negedge hclk);
      chk("post_rst_ready", m_rdy, 1); chk("post_rst_resp", m_resp, 0); chk("post_rst_cs", m_cs, 0);
      @(posedge hclk); #1;
      hsel = 0;
      xfer(1'b0, 3'd2, 16'h0040, 32'h0, 1'b0, o);
      chk("post_rst_read", o.rd, ref_word(1, 16'h0040));
      chk("post_rst_waits", o.waits, 3);

      // Randomized mix against the byte-array model
      for (int n = 0; n < 400; n++) begin
         bit          wr, e;
         logic [2:0]  sz;
         logic [15:0] a;
         logic [31:0] wd;
         int          d;
         d  = $urandom_range(0, 1);
         dut_sel = d[0];
         for (int g = $urandom_range(0, 2); g > 0; g--) begin
            if ($urandom_range(0, 1) == 0) begin
               hsel = 0; htrans = 2'($urandom); haddr = 16'($urandom); hwrite = 1'($urandom);
            end else begin
               hsel = 1; htrans = 2'($urandom_range(0, 1)); haddr = 16'($urandom);
            end
            @(negedge hclk);
            chk("idle_cs", m_cs, 0); chk("idle_ready", m_rdy, 1); chk("idle_resp", m_resp, 0);
            @(posedge hclk); #1;
         end
         wr = 1'($urandom);
         sz = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
         a  = ($urandom_range(0, 9) < 7) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         if ($urandom_range(0, 4) != 0 && sz <= 3'd2) a = a & ~16'((1 << sz) - 1);
         wd = $urandom;
         e  = ref_err(d, sz, a);
         xfer(wr, sz, a, wd, 1'($urandom), o);
         chk("rnd_err", o.err, e);
         chk("rnd_waits", o.waits, e ? 1 : (wr ? ws_of(d) : ws_of(d) + 1));
         chk("rnd_strobes", o.strobes, e ? 0 : 1);
         chk("rnd_resp_cycles", o.resp_cyc, e ? 2 : 0);
         chk("rnd_hrdata", o.rd, (e || wr) ? 32'd0 : ref_word(d, a));
         if (!e) begin
            chk("rnd_be", o.be, ref_be(sz, a));
            chk("rnd_sram_addr", o.sa, a[15:2]);
            chk("rnd_wdata", o.bad_wd, 0);
            if (wr) ref_write(d, sz, a, wd);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
